// File: rtl/bc_pkg.sv
// Shared types and constants for the BullsCows input/display path.
package bc_pkg;

    typedef logic [3:0] digit_t;
    typedef logic [5:0] dspl_code_t;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        VALID   = 1'b1
    } entry_state_t;

    localparam digit_t     MAX_DIGIT  = 4'd9;
    localparam int         NUM_DIGITS = 4;
    localparam dspl_code_t DSPL_BLANK = 6'b0;

    // Lit display slot: {en, hex, dp}.
    function automatic dspl_code_t dspl_encode(digit_t dig, logic dp);
        return {1'b1, dig, dp};
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Synchronizes a raw push button, debounces it and emits a 1-cycle pulse
// on each debounced rising edge.
module button_debouncer #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_level,
    output logic press
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   press_q, press_d;

    assign synced = sync_q[SYNC_STAGES-1];

    // Counter runs only while the synced level disagrees with the debounced one;
    // any return to agreement (i.e. a bounce) restarts it from zero.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        press_d = 1'b0;
        if (synced != level_q) begin
            if (cnt_q == LAST) begin
                level_d = synced;
                press_d = synced;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Synchronizer chain, debounce counter, debounced level and press pulse.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], btn_raw};
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    assign btn_level = level_q;
    assign press     = press_q;

endmodule

// File: rtl/code_entry.sv
// Collects four distinct decimal digits from switches + enter button and offers
// them as a guess over valid/ready, echoing the entry on four display slots.
module code_entry
    import bc_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  code,
    input  logic        enter_button,
    input  logic        guess_ready,
    output logic        guess_valid,
    output logic [15:0] guess,
    output logic [2:0]  digit_count,
    output logic        reject,
    output logic [5:0]  d1,
    output logic [5:0]  d2,
    output logic [5:0]  d3,
    output logic [5:0]  d4
);

    logic btn_level;
    logic press;
    logic press_evt;

    entry_state_t                  state_q, state_d;
    logic [2:0]                    count_q, count_d;
    digit_t     [NUM_DIGITS-1:0]   dig_q, dig_d;
    logic [15:0]                   guess_q, guess_d;
    logic                          reject_q, reject_d;
    dspl_code_t [NUM_DIGITS-1:0]   dspl_q, dspl_d;

    logic code_ok;
    logic is_dup;
    logic accept;
    logic transfer;

    button_debouncer #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clock     (clock),
        .reset     (reset),
        .btn_raw   (enter_button),
        .btn_level (btn_level),
        .press     (press)
    );

    // A press pulse is only meaningful while the debounced level is high.
    assign press_evt = press & btn_level;
    assign code_ok   = (code <= MAX_DIGIT);
    assign accept    = (state_q == COLLECT) && press_evt && code_ok && !is_dup;
    assign transfer  = (state_q == VALID) && guess_ready;

    // Duplicate check against the digits accepted so far only.
    always_comb begin
        is_dup = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if ((3'(i) < count_q) && (dig_q[i] == code)) begin
                is_dup = 1'b1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: fourth accepted digit completes the guess, transfer reopens entry.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            COLLECT: if (accept && (count_q == 3'd3)) state_d = VALID;
            VALID:   if (transfer)                    state_d = COLLECT;
            default: state_d = COLLECT;
        endcase
    end

    // FSM outputs: next values of the digit slots, count, guess, reject and display.
    always_comb begin
        count_d  = count_q;
        dig_d    = dig_q;
        guess_d  = guess_q;
        reject_d = 1'b0;
        if ((state_q == COLLECT) && press_evt) begin
            if (accept) begin
                dig_d[count_q[1:0]] = code;
                count_d             = count_q + 3'd1;
                if (count_q == 3'd3) begin
                    guess_d = {dig_q[0], dig_q[1], dig_q[2], code};
                end
            end else begin
                reject_d = 1'b1;
            end
        end
        // Guess register deliberately keeps its value across a transfer.
        if (transfer) begin
            count_d = 3'd0;
            dig_d   = '0;
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            dspl_d[i] = (3'(i) < count_d) ? dspl_encode(dig_d[i], state_d == VALID) : DSPL_BLANK;
        end
    end

    // Datapath registers; every output comes straight from here or the state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q  <= 3'd0;
            dig_q    <= '0;
            guess_q  <= 16'h0000;
            reject_q <= 1'b0;
            dspl_q   <= '0;
        end else begin
            count_q  <= count_d;
            dig_q    <= dig_d;
            guess_q  <= guess_d;
            reject_q <= reject_d;
            dspl_q   <= dspl_d;
        end
    end

    assign guess_valid = (state_q == VALID);
    assign guess       = guess_q;
    assign digit_count = count_q;
    assign reject      = reject_q;
    assign d1          = dspl_q[0];
    assign d2          = dspl_q[1];
    assign d3          = dspl_q[2];
    assign d4          = dspl_q[3];

endmodule

// File: tb/tb_code_entry.sv
// Self-checking bench for code_entry: directed scenarios plus randomized presses,
// compared every cycle against a behavioural model of the entry rules.
module tb_code_entry;

    localparam int unsigned DEB = 4;
    localparam int unsigned SYN = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  code = 4'd0;
    logic        enter_button = 1'b0;
    logic        guess_ready = 1'b0;
    logic        guess_valid;
    logic [15:0] guess;
    logic [2:0]  digit_count;
    logic        reject;
    logic [5:0]  d1, d2, d3, d4;

    code_entry #(
        .DEBOUNCE_CYCLES (DEB),
        .SYNC_STAGES     (SYN)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .code         (code),
        .enter_button (enter_button),
        .guess_ready  (guess_ready),
        .guess_valid  (guess_valid),
        .guess        (guess),
        .digit_count  (digit_count),
        .reject       (reject),
        .d1           (d1),
        .d2           (d2),
        .d3           (d3),
        .d4           (d4)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;
    int rej_seen = 0;
    bit chk_en = 1'b0;
    bit rand_ready = 1'b0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [SYN-1:0] m_sync = '0;     // raw button delayed by the synchronizer
    bit             m_run_val = 1'b0; // value of the current run of synced samples
    int             m_run_len = 0;
    bit             m_level = 1'b0;
    bit             m_press = 1'b0;
    logic [3:0]     m_dig [4];
    int             m_cnt = 0;
    bit             m_valid = 1'b0;
    bit             m_reject = 1'b0;
    logic [15:0]    m_guess = 16'h0;

    always @(posedge clock or negedge reset) begin
        logic s;
        bit   old_press;
        bit   dup;
        if (!reset) begin
            m_sync = '0; m_run_val = 1'b0; m_run_len = 0; m_level = 1'b0; m_press = 1'b0;
            m_cnt = 0; m_valid = 1'b0; m_reject = 1'b0; m_guess = 16'h0;
        end else begin
            s = m_sync[SYN-1];
            old_press = m_press;
            // Level follows the synced button once it has held a new value DEB cycles.
            if (s == m_run_val) m_run_len++;
            else begin
                m_run_val = s;
                m_run_len = 1;
            end
            m_press = 1'b0;
            if (m_run_len >= int'(DEB) && m_run_val != m_level) begin
                m_level = m_run_val;
                m_press = m_level;
            end
            m_sync = {m_sync[SYN-2:0], enter_button};
            // Entry rules.
            m_reject = 1'b0;
            if (!m_valid) begin
                if (old_press) begin
                    dup = 1'b0;
                    for (int i = 0; i < m_cnt; i++) if (m_dig[i] == code) dup = 1'b1;
                    if (code > 4'd9 || dup) m_reject = 1'b1;
                    else begin
                        m_dig[m_cnt] = code;
                        m_cnt++;
                        if (m_cnt == 4) begin
                            m_valid = 1'b1;
                            m_guess = {m_dig[0], m_dig[1], m_dig[2], m_dig[3]};
                        end
                    end
                end
            end else if (guess_ready) begin
                m_valid = 1'b0;
                m_cnt = 0;
            end
        end
    end

    function automatic logic [5:0] exp_disp(input int i);
        if (i < m_cnt) return {1'b1, m_dig[i], m_valid};
        return 6'b0;
    endfunction

    // Per-cycle comparison against the model.
    always @(negedge clock) begin
        if (chk_en) begin
            check("guess_valid", 16'(guess_valid), 16'(m_valid));
            check("guess", guess, m_guess);
            check("digit_count", 16'(digit_count), 16'(m_cnt));
            check("reject", 16'(reject), 16'(m_reject));
            check("d1", 16'(d1), 16'(exp_disp(0)));
            check("d2", 16'(d2), 16'(exp_disp(1)));
            check("d3", 16'(d3), 16'(exp_disp(2)));
            check("d4", 16'(d4), 16'(exp_disp(3)));
        end
        if (reject === 1'b1) rej_seen++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clock);
        if (rand_ready) guess_ready = ($urandom_range(0, 3) == 0);
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic press_clean(input logic [3:0] c);
        code = c;
        enter_button = 1'b1;
        ticks(DEB + SYN + 3);
        enter_button = 1'b0;
        ticks(DEB + SYN + 3);
    endtask

    task automatic glitches(input int n);
        repeat (n) begin
            enter_button = 1'b1;
            ticks($urandom_range(1, 2));
            enter_button = 1'b0;
            ticks($urandom_range(1, 2));
        end
    endtask

    task automatic press_bouncy(input logic [3:0] c);
        code = c;
        glitches($urandom_range(1, 3));
        enter_button = 1'b1;
        ticks(10);
        enter_button = 1'b0;
        ticks(DEB + SYN + 3);
    endtask

    task automatic reset_pulse();
        @(negedge clock);
        #2 reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 16'(guess_valid), 16'h0);
        check({tag, "_guess"}, guess, 16'h0);
        check({tag, "_count"}, 16'(digit_count), 16'h0);
        check({tag, "_reject"}, 16'(reject), 16'h0);
        check({tag, "_disp"}, 16'({d1, d2}), 16'h0);
        check({tag, "_disp34"}, 16'({d3, d4}), 16'h0);
    endtask

    initial begin
        int rej0;
        int n;
        int kind;
        logic [3:0] c;

        // Reset state.
        #2 reset = 1'b0;
        #1 check_all_zero("reset");
        chk_en = 1'b1;
        ticks(3);
        reset = 1'b1;
        ticks(2);

        // 1. Clean entry of 1,2,3,4.
        press_clean(4'd1);
        press_clean(4'd2);
        press_clean(4'd3);
        press_clean(4'd4);
        check("t1_guess", guess, 16'h1234);
        check("t1_valid", 16'(guess_valid), 16'h1);
        check("t1_count", 16'(digit_count), 16'h4);
        check("t1_d1", 16'(d1), 16'h23);
        check("t1_d2", 16'(d2), 16'h25);
        check("t1_d3", 16'(d3), 16'h27);
        check("t1_d4", 16'(d4), 16'h29);

        // 4. Hold VALID with ready low and presses; then a one-cycle transfer.
        rej0 = rej_seen;
        press_clean(4'd5);
        press_clean(4'd9);
        ticks(4);
        check("t4_guess_held", guess, 16'h1234);
        check("t4_count_held", 16'(digit_count), 16'h4);
        check("t4_no_reject", 16'(rej_seen - rej0), 16'h0);
        guess_ready = 1'b1;
        tick();
        guess_ready = 1'b0;
        check("t4_valid_clr", 16'(guess_valid), 16'h0);
        check("t4_count_clr", 16'(digit_count), 16'h0);
        check("t4_disp_clr", 16'({d1, d2}), 16'h0);
        check("t4_guess_kept", guess, 16'h1234);

        // 2. Bouncy press gives one digit; glitches alone give nothing.
        press_bouncy(4'd6);
        check("t2_count", 16'(digit_count), 16'h1);
        check("t2_d1", 16'(d1), 16'h2C);
        code = 4'd3;
        glitches(4);
        ticks(DEB + SYN + 3);
        check("t2_glitch_count", 16'(digit_count), 16'h1);

        // 3. Duplicate and out-of-range rejections after 5,7.
        reset_pulse();
        press_clean(4'd5);
        press_clean(4'd7);
        rej0 = rej_seen;
        press_clean(4'd7);
        check("t3_dup_reject", 16'(rej_seen - rej0), 16'h1);
        press_clean(4'hA);
        check("t3_range_reject", 16'(rej_seen - rej0), 16'h2);
        check("t3_count2", 16'(digit_count), 16'h2);
        press_clean(4'd0);
        check("t3_count3", 16'(digit_count), 16'h3);
        press_clean(4'd1);
        check("t3_guess", guess, 16'h5701);

        // 5. Press lands on the transfer cycle: dropped, not queued.
        rej0 = rej_seen;
        code = 4'd2;
        enter_button = 1'b1;
        ticks(DEB + SYN);
        guess_ready = 1'b1;
        tick();
        guess_ready = 1'b0;
        check("t5_valid", 16'(guess_valid), 16'h0);
        check("t5_count", 16'(digit_count), 16'h0);
        check("t5_reject", 16'(reject), 16'h0);
        ticks(3);
        enter_button = 1'b0;
        ticks(DEB + SYN + 3);
        check("t5_still_empty", 16'(digit_count), 16'h0);
        check("t5_no_reject", 16'(rej_seen - rej0), 16'h0);
        press_clean(4'd8);
        check("t5_slot0", 16'(d1), 16'h30);

        // 6. Reset mid-entry and mid-debounce, button held through release.
        press_clean(4'd2);
        code = 4'd4;
        enter_button = 1'b1;
        ticks(2);
        #2 reset = 1'b0;
        #1 check_all_zero("t6");
        tick();
        tick();
        reset = 1'b1;
        n = 0;
        while (digit_count !== 3'd1 && n < 20) begin
            tick();
            n++;
        end
        check("t6_press_latency", 16'(n), 16'd7);
        enter_button = 1'b0;
        ticks(DEB + SYN + 3);

        // Randomized phase.
        rand_ready = 1'b1;
        for (int r = 0; r < 80; r++) begin
            kind = $urandom_range(0, 11);
            c = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            if (kind == 0) reset_pulse();
            else if (kind < 3) begin
                code = c;
                glitches($urandom_range(1, 4));
                ticks(DEB + SYN + 2);
            end else if (kind < 7) press_clean(c);
            else press_bouncy(c);
        end
        rand_ready = 1'b0;
        guess_ready = 1'b0;
        ticks(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
